// File: rtl/blkram_rd_pkg.sv
// Shared definitions for the block-RAM burst reader.
// Holds the default geometry of the 4k x 9 block RAM the reader is paired
// with, the reader FSM state type, and the RAM read latency that the
// return-data pipeline in the top level has to cover.
package blkram_rd_pkg;

  localparam int unsigned AddrWidthDef = 12;
  localparam int unsigned DataWidthDef = 9;

  // Cycles from an enabled address to data on ram_douta: one for the array
  // read, one for the RAM's output register.
  localparam int unsigned RdLatency = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/blkram_burst_reader_if.sv
// Bus bundle between the burst reader and its environment.
// Groups three things: the command handshake (cmd_*), the read-only RAM
// port (ram_*), and the output stream (out_*) together with the busy flag.
//   master : the reader. It drives cmd_ready, ram_*, out_valid/data/last
//            and busy.
//   slave  : the environment. It drives the command, ram_douta and
//            out_ready.
interface blkram_burst_reader_if
  import blkram_rd_pkg::*;
#(
  parameter int unsigned AddrWidth = AddrWidthDef,
  parameter int unsigned DataWidth = DataWidthDef
);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [AddrWidth-1:0] cmd_addr;
  logic [AddrWidth:0]   cmd_len;

  logic                 ram_ena;
  logic                 ram_regcea;
  logic                 ram_wea;
  logic [AddrWidth-1:0] ram_addra;
  logic [DataWidth-1:0] ram_douta;

  logic                 out_valid;
  logic                 out_ready;
  logic [DataWidth-1:0] out_data;
  logic                 out_last;

  logic                 busy;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, ram_douta, out_ready,
    output cmd_ready, ram_ena, ram_regcea, ram_wea, ram_addra,
           out_valid, out_data, out_last, busy
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, ram_douta, out_ready,
    input  cmd_ready, ram_ena, ram_regcea, ram_wea, ram_addra,
           out_valid, out_data, out_last, busy
  );

endinterface

// File: rtl/rd_skid_fifo.sv
// Small synchronous FIFO that buffers words returned by the RAM until the
// stream consumer takes them. A push and a pop may happen in the same cycle.
// The caller must never push when the FIFO is full or pop when it is empty.
// Ports:
//   clka, resetn : clock and asynchronous active-low reset.
//   push_i       : write wdata_i at the tail.
//   wdata_i      : word to write.
//   pop_i        : drop the head entry.
//   rdata_o      : head entry. Only meaningful when empty_o is low.
//   count_o      : number of occupied entries.
//   empty_o      : high when count_o is 0.
//   full_o       : high when count_o equals Depth.
module rd_skid_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 4
) (
  input  logic                         clka,
  input  logic                         resetn,
  input  logic                         push_i,
  input  logic [Width-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [Width-1:0]             rdata_o,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  // Advance a pointer. The explicit wrap lets Depth be any value, not only
  // a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // The storage array has no reset; the pointers decide what is valid.
  always_ff @(posedge clka) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clka or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));

endmodule

// File: rtl/blkram_burst_reader.sv
// Streaming burst read engine for a single-port block RAM with a registered
// output. It takes one (addr, len) command at a time and issues read-only
// accesses to consecutive addresses, wrapping at the top of the address
// space. It tracks the two-cycle RAM latency with a valid/last shift
// register and buffers the returned words in a small FIFO, then presents
// them on a valid/ready stream. The last word of the burst carries
// out_last.
// Issue is credit based. A read is only started when the words already
// buffered plus the reads still in flight leave room in the FIFO. This
// means a stalled consumer can never cause a returned word to be dropped.
// Ports:
//   clka   : single clock for the reader and the RAM it drives.
//   resetn : asynchronous active-low reset. It is allowed mid-burst and
//            discards all in-flight data.
//   bus    : master side of blkram_burst_reader_if (command, RAM port,
//            output stream, busy).
module blkram_burst_reader
  import blkram_rd_pkg::*;
#(
  parameter int unsigned AddrWidth = AddrWidthDef,
  parameter int unsigned DataWidth = DataWidthDef,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                  clka,
  input  logic                  resetn,
  blkram_burst_reader_if.master bus
);

  localparam int unsigned LenW  = AddrWidth + 1;
  localparam int unsigned CntW  = $clog2(FifoDepth + 1);
  localparam int unsigned UsedW = CntW + 1;

  rd_state_e            state_q;
  logic [AddrWidth-1:0] cur_addr_q;
  logic [LenW-1:0]      remaining_q;
  logic                 cmd_ready_q, busy_q;

  logic                 vld_p1_q, last_p1_q;
  logic                 vld_p2_q, last_p2_q;

  logic [CntW-1:0]      fifo_count;
  logic                 fifo_empty, fifo_full;
  logic [DataWidth:0]   fifo_rdata;

  logic [UsedW-1:0]     used;
  logic                 issue, push, pop, head_last;

  // Every read already started occupies a FIFO slot: either it is stored,
  // or it is still in the RAM pipeline. The count used here is the value
  // before any pop in this cycle, so a slot freed by a pop is only reused
  // one cycle later.
  always_comb begin
    used = UsedW'(fifo_count) + UsedW'(vld_p1_q) + UsedW'(vld_p2_q);
  end

  assign issue     = (state_q == RUN) && (used < UsedW'(FifoDepth));
  assign pop       = !fifo_empty && bus.out_ready;
  assign head_last = fifo_rdata[DataWidth];
  // The credit rule already prevents pushing into a full FIFO.
  // The full check is a backstop only.
  assign push      = vld_p2_q && !fifo_full;

  always_ff @(posedge clka or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A zero-length command is accepted and completes immediately.
          if (bus.cmd_valid && (bus.cmd_len != '0)) begin
            cur_addr_q  <= bus.cmd_addr;
            remaining_q <= bus.cmd_len;
            state_q     <= RUN;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        RUN: begin
          if (issue) begin
            cur_addr_q  <= cur_addr_q + AddrWidth'(1);
            remaining_q <= remaining_q - LenW'(1);
            if (remaining_q == LenW'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && head_last) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // ---- p1: RAM array read, output register enabled next ----
  // ---- p2: ram_douta valid, written into the FIFO ----
  always_ff @(posedge clka or negedge resetn) begin
    if (!resetn) begin
      vld_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
      vld_p2_q  <= 1'b0;
      last_p2_q <= 1'b0;
    end else begin
      vld_p1_q  <= issue;
      last_p1_q <= issue && (remaining_q == LenW'(1));
      vld_p2_q  <= vld_p1_q;
      last_p2_q <= last_p1_q;
    end
  end

  rd_skid_fifo #(
    .Width (DataWidth + 1),
    .Depth (FifoDepth)
  ) u_fifo (
    .clka    (clka),
    .resetn  (resetn),
    .push_i  (push),
    .wdata_i ({last_p2_q, bus.ram_douta}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.busy       = busy_q;
  assign bus.ram_ena    = issue;
  assign bus.ram_regcea = vld_p1_q;
  assign bus.ram_wea    = 1'b0;
  assign bus.ram_addra  = cur_addr_q;
  assign bus.out_valid  = !fifo_empty;
  // Gate the head with empty. The FIFO storage has no reset, so this keeps
  // the stream outputs at zero whenever nothing is buffered.
  assign bus.out_data   = fifo_empty ? '0 : fifo_rdata[DataWidth-1:0];
  assign bus.out_last   = !fifo_empty && head_last;

endmodule

// File: tb/tb_blkram_burst_reader.sv
// Directed-plus-random bench for blkram_burst_reader, with a behavioural
// 4k x 9 registered-output RAM preloaded so that data = addr & 0x1FF.
// Expected words come from that addressing rule. The credit limit is
// checked as started-reads minus accepted-words, never from DUT internals.
module tb_blkram_burst_reader;
  import blkram_rd_pkg::*;

  localparam int AW = 12;
  localparam int DW = 9;
  localparam int FD = 4;

  logic clka = 1'b0;
  logic resetn = 1'b0;
  always #5 clka = ~clka;

  blkram_burst_reader_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();

  blkram_burst_reader #(.AddrWidth(AW), .DataWidth(DW), .FifoDepth(FD)) dut (
    .clka   (clka),
    .resetn (resetn),
    .bus    (bus)
  );

  // Behavioural RAM: array read on ena, output register loaded on regcea.
  logic [DW-1:0] mem [1 << AW];
  logic [DW-1:0] ram_lat;
  always @(posedge clka) begin
    if (bus.ram_ena)    ram_lat <= mem[bus.ram_addra];
    if (bus.ram_regcea) bus.ram_douta <= ram_lat;
  end

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int issued = 0;
  int popped = 0;
  bit prev_ena = 1'b0;
  logic [AW-1:0] exp_addr;
  int accept_cyc, first_valid_cyc, last_pop_cyc;
  bit saw_valid, saw_busy;
  logic [DW-1:0] got_d[$];
  logic          got_l[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample everything mid-cycle, then step past the next edge.
  task automatic cyc();
    @(negedge clka);
    cyc_n++;
    chk("wea_zero", 32'(bus.ram_wea), 32'd0);
    chk("regcea_follows_ena", 32'(bus.ram_regcea), 32'(prev_ena));
    chk("cmd_ready_vs_busy", 32'(bus.cmd_ready), 32'(!bus.busy));
    chk("outstanding_bound", 32'((issued - popped) <= FD), 32'd1);
    if (bus.ram_ena) begin
      chk("credit_at_issue", 32'((issued - popped) < FD), 32'd1);
      chk("issue_addr", 32'(bus.ram_addra), 32'(exp_addr));
      exp_addr = exp_addr + AW'(1);
      issued++;
    end
    if (bus.cmd_valid && bus.cmd_ready) accept_cyc = cyc_n;
    if (bus.busy) saw_busy = 1'b1;
    if (bus.out_valid) begin
      saw_valid = 1'b1;
      if (first_valid_cyc < 0) first_valid_cyc = cyc_n;
    end
    if (bus.out_valid && bus.out_ready) begin
      got_d.push_back(bus.out_data);
      got_l.push_back(bus.out_last);
      popped++;
      if (bus.out_last) last_pop_cyc = cyc_n;
    end
    prev_ena = bus.ram_ena;
    @(posedge clka);
    #1;
  endtask

  // mode 0: out_ready held high; mode 1: random ready with 10-cycle stalls.
  task automatic burst(input logic [AW-1:0] a, input int n, input int mode, input string tag);
    int budget;
    int stall;
    int r;
    int ea;
    got_d.delete();
    got_l.delete();
    first_valid_cyc = -1;
    accept_cyc = -1;
    last_pop_cyc = -1;
    exp_addr = a;
    bus.out_ready = 1'b1;
    budget = 0;
    while (!bus.cmd_ready && budget < 20) begin
      cyc();
      budget++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = (AW + 1)'(n);
    cyc();
    bus.cmd_valid = 1'b0;
    budget = 0;
    stall = 0;
    while (got_d.size() < n && budget < n * 4 + 200) begin
      if (mode == 1) begin
        if (budget == 5) stall = 10;
        if (stall > 0) begin
          bus.out_ready = 1'b0;
          stall--;
        end else begin
          r = int'($urandom_range(0, 15));
          if (r == 0) begin
            stall = 10;
            bus.out_ready = 1'b0;
          end else begin
            bus.out_ready = (r > 5);
          end
        end
      end
      cyc();
      budget++;
    end
    bus.out_ready = 1'b1;
    chk({tag, "_word_count"}, 32'(got_d.size()), 32'(n));
    for (int i = 0; i < got_d.size() && i < n; i++) begin
      ea = (int'(a) + i) % (1 << AW);
      chk({tag, "_data"}, 32'(got_d[i]), 32'(ea & 'h1FF));
      chk({tag, "_last"}, 32'(got_l[i]), 32'(i == n - 1));
    end
    if (mode == 0) begin
      chk({tag, "_first_latency"}, 32'(first_valid_cyc - accept_cyc), 32'd4);
      chk({tag, "_last_pop_time"}, 32'(last_pop_cyc - accept_cyc), 32'(3 + n));
    end
    chk({tag, "_ready_after"}, 32'(bus.cmd_ready), 32'd1);
    chk({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    repeat (3) cyc();
    chk({tag, "_no_extra_words"}, 32'(got_d.size()), 32'(n));
  endtask

  initial begin
    int n0;
    int a;
    int n;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i & 'h1FF);
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clka);
    #1;
    chk("rst_ram_ena", 32'(bus.ram_ena), 32'd0);
    chk("rst_regcea", 32'(bus.ram_regcea), 32'd0);
    chk("rst_addra", 32'(bus.ram_addra), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clka);
    resetn = 1'b1;
    @(posedge clka);
    #1;

    burst(AW'('h010), 8, 0, "b010");
    burst(AW'('hFFE), 4, 0, "wrap");
    burst(AW'($urandom_range(0, (1 << AW) - 1)), 16, 1, "stall16");

    // Zero-length command: accepted, nothing happens
    n0 = issued;
    saw_valid = 1'b0;
    saw_busy = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = AW'('h333);
    bus.cmd_len   = '0;
    cyc();
    bus.cmd_valid = 1'b0;
    repeat (5) begin
      chk("len0_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      cyc();
    end
    chk("len0_no_issue", 32'(issued), 32'(n0));
    chk("len0_no_valid", 32'(saw_valid), 32'd0);
    chk("len0_no_busy", 32'(saw_busy), 32'd0);
    burst(AW'('h123), 1, 0, "single");

    // Reset in the middle of a stalled burst with two reads in flight
    exp_addr = AW'('h5A0);
    bus.out_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = AW'('h5A0);
    bus.cmd_len   = (AW + 1)'(16);
    cyc();
    bus.cmd_valid = 1'b0;
    n = 0;
    while ((issued - popped) < FD && n < 30) begin
      cyc();
      n++;
    end
    chk("pre_rst_credits_used", 32'(issued - popped), 32'(FD));
    chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_ram_ena", 32'(bus.ram_ena), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("mid_rst_regcea", 32'(bus.ram_regcea), 32'd0);
    chk("mid_rst_out_last", 32'(bus.out_last), 32'd0);
    repeat (2) @(posedge clka);
    @(negedge clka);
    resetn = 1'b1;
    issued = 0;
    popped = 0;
    prev_ena = 1'b0;
    @(posedge clka);
    #1;
    burst(AW'('h200), 3, 0, "post_rst");

    // Random bursts with random consumer back-pressure
    repeat (4) begin
      a = int'($urandom_range(0, (1 << AW) - 1));
      n = int'($urandom_range(1, 40));
      burst(AW'(a), n, 1, "rnd");
    end

    // Full-size burst across the address wrap
    burst(AW'('h800), 4096, 0, "full4k");
    chk("full4k_last_addr", 32'(exp_addr - AW'(1)), 32'h7FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
